cdb_arbiter: RTL and testbench

- Shares the single result write-back port (common data bus, CDB) between the ALU result source and the LSB load result source.
- The CDB feeds the ROB result-ready update and the RS/LSB operand wake-up.
- Each source has a small skid FIFO; a round-robin arbiter grants one entry per cycle to a registered CDB output.
- Misprediction flush (clr) discards all buffered results.

---
 rtl/cdb_arbiter_if.sv | 60 ++++++
 rtl/cdb_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Bundle of the CDB arbiter's control, producer and broadcast signals.
// The master side drives the control and producer signals; the slave side is the arbiter.
interface cdb_arbiter_if #(
    parameter int POS_W  = 5,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Global control
    logic              rdy;
    logic              clr;

    // ALU result source
    logic              alu_valid;
    logic [POS_W-1:0]  alu_rob_pos;
    logic [DATA_W-1:0] alu_val;
    logic              alu_jump;
    logic [ADDR_W-1:0] alu_pc;
    logic              alu_ready;

    // LSB load result source
    logic              lsb_valid;
    logic [POS_W-1:0]  lsb_rob_pos;
    logic [DATA_W-1:0] lsb_val;
    logic              lsb_ready;

    // Common data bus broadcast
    logic              cdb_valid;
    logic [POS_W-1:0]  cdb_rob_pos;
    logic [DATA_W-1:0] cdb_val;
    logic              cdb_jump;
    logic [ADDR_W-1:0] cdb_pc;
    logic              cdb_src;

    // Occupancy
    logic [CNT_W-1:0]  alu_count;
    logic [CNT_W-1:0]  lsb_count;

    modport master (
        output rdy, clr,
        output alu_valid, alu_rob_pos, alu_val, alu_jump, alu_pc,
        input  alu_ready,
        output lsb_valid, lsb_rob_pos, lsb_val,
        input  lsb_ready,
        input  cdb_valid, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc, cdb_src,
        input  alu_count, lsb_count
    );

    modport slave (
        input  rdy, clr,
        input  alu_valid, alu_rob_pos, alu_val, alu_jump, alu_pc,
        output alu_ready,
        input  lsb_valid, lsb_rob_pos, lsb_val,
        output lsb_ready,
        output cdb_valid, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc, cdb_src,
        output alu_count, lsb_count
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: two small skid FIFOs (ALU results, LSB load results) sharing one
// registered write-back bus. The grant is round-robin, one entry per cycle.
// A flush (clr) behaves like reset on every buffer and on the bus registers.
module cdb_arbiter #(
    parameter int POS_W  = 5,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic           clk,
    input  logic           rst,
    cdb_arbiter_if.slave   bus
);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int ALU_E_W   = POS_W + DATA_W + 1 + ADDR_W;
    localparam int LSB_E_W   = POS_W + DATA_W;
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSB = 1'b1;

    // Entry storage. It is written at the tail only, and the head entry is read
    // straight into the registered bus outputs.
    logic [ALU_E_W-1:0] alu_mem [DEPTH];
    logic [LSB_E_W-1:0] lsb_mem [DEPTH];

    logic [PTR_W-1:0]  alu_head_q, alu_head_d, alu_tail_q, alu_tail_d;
    logic [PTR_W-1:0]  lsb_head_q, lsb_head_d, lsb_tail_q, lsb_tail_d;
    logic [CNT_W-1:0]  alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
    logic              last_grant_q, last_grant_d;

    logic              cdb_valid_q, cdb_valid_d;
    logic [POS_W-1:0]  cdb_pos_q, cdb_pos_d;
    logic [DATA_W-1:0] cdb_val_q, cdb_val_d;
    logic              cdb_jump_q, cdb_jump_d;
    logic [ADDR_W-1:0] cdb_pc_q, cdb_pc_d;
    logic              cdb_src_q, cdb_src_d;

    logic              alu_ready, lsb_ready;
    logic              alu_push, lsb_push;
    logic              alu_ne, lsb_ne;
    logic              grant_alu, grant_lsb;

    logic [POS_W-1:0]  alu_h_pos, lsb_h_pos;
    logic [DATA_W-1:0] alu_h_val, lsb_h_val;
    logic              alu_h_jump;
    logic [ADDR_W-1:0] alu_h_pc;

    // Ready depends only on the current occupancy. A pop in the same cycle does not free a slot.
    assign alu_ready = (alu_cnt_q < CNT_W'(DEPTH));
    assign lsb_ready = (lsb_cnt_q < CNT_W'(DEPTH));

    // Pushes are ignored while stalled, and they are dropped during a flush or reset.
    assign alu_push  = bus.rdy && !bus.clr && !rst && bus.alu_valid && alu_ready;
    assign lsb_push  = bus.rdy && !bus.clr && !rst && bus.lsb_valid && lsb_ready;

    // Arbitration uses the occupancy before this cycle's push, so a new entry
    // cannot be broadcast until at least one edge after it is written.
    assign alu_ne    = (alu_cnt_q != '0);
    assign lsb_ne    = (lsb_cnt_q != '0);
    assign grant_alu = bus.rdy && alu_ne && (!lsb_ne || (last_grant_q == SRC_LSB));
    assign grant_lsb = bus.rdy && lsb_ne && !grant_alu;

    assign {alu_h_pos, alu_h_val, alu_h_jump, alu_h_pc} = alu_mem[alu_head_q];
    assign {lsb_h_pos, lsb_h_val}                       = lsb_mem[lsb_head_q];

    // Next-state logic for the pointers, counts, round-robin state and bus registers.
    always_comb begin
        alu_head_d   = alu_head_q;
        alu_tail_d   = alu_tail_q;
        alu_cnt_d    = alu_cnt_q;
        lsb_head_d   = lsb_head_q;
        lsb_tail_d   = lsb_tail_q;
        lsb_cnt_d    = lsb_cnt_q;
        last_grant_d = last_grant_q;
        cdb_valid_d  = cdb_valid_q;
        cdb_pos_d    = cdb_pos_q;
        cdb_val_d    = cdb_val_q;
        cdb_jump_d   = cdb_jump_q;
        cdb_pc_d     = cdb_pc_q;
        cdb_src_d    = cdb_src_q;

        if (bus.rdy) begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (alu_push)  alu_tail_d = alu_tail_q + PTR_W'(1);
            if (grant_alu) alu_head_d = alu_head_q + PTR_W'(1);
            if (lsb_push)  lsb_tail_d = lsb_tail_q + PTR_W'(1);
            if (grant_lsb) lsb_head_d = lsb_head_q + PTR_W'(1);
            alu_cnt_d = alu_cnt_q + CNT_W'(alu_push) - CNT_W'(grant_alu);
            lsb_cnt_d = lsb_cnt_q + CNT_W'(lsb_push) - CNT_W'(grant_lsb);

            if (grant_alu) begin
                last_grant_d = SRC_ALU;
                cdb_valid_d  = 1'b1;
                cdb_pos_d    = alu_h_pos;
                cdb_val_d    = alu_h_val;
                cdb_jump_d   = alu_h_jump;
                cdb_pc_d     = alu_h_pc;
                cdb_src_d    = SRC_ALU;
            end else if (grant_lsb) begin
                last_grant_d = SRC_LSB;
                cdb_valid_d  = 1'b1;
                cdb_pos_d    = lsb_h_pos;
                cdb_val_d    = lsb_h_val;
                cdb_jump_d   = 1'b0;
                cdb_pc_d     = '0;
                cdb_src_d    = SRC_LSB;
            end else begin
                // An idle cycle drops valid only. The payload keeps its last value.
                cdb_valid_d  = 1'b0;
            end
        end
    end

    // State registers. A flush clears them the same way reset does, regardless of rdy.
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            alu_head_q   <= '0;
            alu_tail_q   <= '0;
            alu_cnt_q    <= '0;
            lsb_head_q   <= '0;
            lsb_tail_q   <= '0;
            lsb_cnt_q    <= '0;
            last_grant_q <= SRC_LSB;
            cdb_valid_q  <= 1'b0;
            cdb_pos_q    <= '0;
            cdb_val_q    <= '0;
            cdb_jump_q   <= 1'b0;
            cdb_pc_q     <= '0;
            cdb_src_q    <= 1'b0;
        end else begin
            alu_head_q   <= alu_head_d;
            alu_tail_q   <= alu_tail_d;
            alu_cnt_q    <= alu_cnt_d;
            lsb_head_q   <= lsb_head_d;
            lsb_tail_q   <= lsb_tail_d;
            lsb_cnt_q    <= lsb_cnt_d;
            last_grant_q <= last_grant_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_pos_q    <= cdb_pos_d;
            cdb_val_q    <= cdb_val_d;
            cdb_jump_q   <= cdb_jump_d;
            cdb_pc_q     <= cdb_pc_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    // Write an accepted ALU result into its tail slot.
    always_ff @(posedge clk) begin
        if (alu_push) alu_mem[alu_tail_q] <= {bus.alu_rob_pos, bus.alu_val, bus.alu_jump, bus.alu_pc};
    end

    // Write an accepted load result into its tail slot.
    always_ff @(posedge clk) begin
        if (lsb_push) lsb_mem[lsb_tail_q] <= {bus.lsb_rob_pos, bus.lsb_val};
    end

    // Catch a producer that offers a result while its FIFO is full. That entry is dropped.
    always_ff @(posedge clk) begin
        if (!rst && !bus.clr && bus.rdy) begin
            assert (!(bus.alu_valid && !alu_ready));
            assert (!(bus.lsb_valid && !lsb_ready));
        end
    end

    assign bus.alu_ready   = alu_ready;
    assign bus.lsb_ready   = lsb_ready;
    assign bus.alu_count   = alu_cnt_q;
    assign bus.lsb_count   = lsb_cnt_q;
    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_rob_pos = cdb_pos_q;
    assign bus.cdb_val     = cdb_val_q;
    assign bus.cdb_jump    = cdb_jump_q;
    assign bus.cdb_pc      = cdb_pc_q;
    assign bus.cdb_src     = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter. A table of hand-computed vectors is applied
// one clock per row. A hand-written sequence then covers the rdy stall.
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.POS_W(5), .DATA_W(32), .ADDR_W(32), .DEPTH(2)) bus ();

    cdb_arbiter #(.POS_W(5), .DATA_W(32), .ADDR_W(32), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rdy, clr;
        logic        av;  logic [4:0] ap; logic [31:0] aval; logic aj; logic [31:0] apc;
        logic        lv;  logic [4:0] lp; logic [31:0] lval;
        logic        ev, es; logic [4:0] ep; logic [31:0] e_val; logic ej; logic [31:0] epc;
        logic [1:0]  eac, elc;
        logic        ear, elr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mkv(
        input logic rdy, input logic clr,
        input logic av, input logic [4:0] ap, input logic [31:0] aval, input logic aj, input logic [31:0] apc,
        input logic lv, input logic [4:0] lp, input logic [31:0] lval,
        input logic ev, input logic es, input logic [4:0] ep, input logic [31:0] e_val,
        input logic ej, input logic [31:0] epc,
        input int eac, input int elc, input logic ear, input logic elr);
        vec_t v;
        v.rdy = rdy; v.clr = clr;
        v.av = av; v.ap = ap; v.aval = aval; v.aj = aj; v.apc = apc;
        v.lv = lv; v.lp = lp; v.lval = lval;
        v.ev = ev; v.es = es; v.ep = ep; v.e_val = e_val; v.ej = ej; v.epc = epc;
        v.eac = 2'(eac); v.elc = 2'(elc); v.ear = ear; v.elr = elr;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.rdy         = v.rdy;
        bus.clr         = v.clr;
        bus.alu_valid   = v.av;
        bus.alu_rob_pos = v.ap;
        bus.alu_val     = v.aval;
        bus.alu_jump    = v.aj;
        bus.alu_pc      = v.apc;
        bus.lsb_valid   = v.lv;
        bus.lsb_rob_pos = v.lp;
        bus.lsb_val     = v.lval;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("check %s: %0h", nm, act);
        end
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        logic [79:0] act, exp;
        act = {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_pos, bus.cdb_val, bus.cdb_jump,
               bus.cdb_pc, bus.alu_count, bus.lsb_count, bus.alu_ready, bus.lsb_ready};
        exp = {v.ev, v.es, v.ep, v.e_val, v.ej, v.epc, v.eac, v.elc, v.ear, v.elr};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL vec%0d: got v=%0b src=%0b pos=%h val=%h j=%0b pc=%h ac=%0d lc=%0d ar=%0b lr=%0b; expected v=%0b src=%0b pos=%h val=%h j=%0b pc=%h ac=%0d lc=%0d ar=%0b lr=%0b",
                     idx, bus.cdb_valid, bus.cdb_src, bus.cdb_rob_pos, bus.cdb_val, bus.cdb_jump,
                     bus.cdb_pc, bus.alu_count, bus.lsb_count, bus.alu_ready, bus.lsb_ready,
                     v.ev, v.es, v.ep, v.e_val, v.ej, v.epc, v.eac, v.elc, v.ear, v.elr);
        end else begin
            $display("vec%0d: v=%0b src=%0b pos=%h val=%h ac=%0d lc=%0d",
                     idx, bus.cdb_valid, bus.cdb_src, bus.cdb_rob_pos, bus.cdb_val,
                     bus.alu_count, bus.lsb_count);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        int first;
        vec_t idle;

        // mkv(rdy,clr, av,ap,aval,aj,apc, lv,lp,lval, ev,es,ep,val,ej,epc, ac,lc,ar,lr)
        // Reset, then idle
        vecs.push_back(mkv(1,0, 0,5'h00,32'h0,0,32'h0, 0,5'h00,32'h0, 0,0,5'h00,32'h0,0,32'h0, 0,0,1,1));
        // Single ALU push, then its broadcast, then valid drops and the payload holds
        vecs.push_back(mkv(1,0, 1,5'h13,32'hDEADBEEF,1,32'h100, 0,5'h00,32'h0, 0,0,5'h00,32'h0,0,32'h0, 1,0,1,1));
        vecs.push_back(mkv(1,0, 0,5'h00,32'h0,0,32'h0, 0,5'h00,32'h0, 1,0,5'h13,32'hDEADBEEF,1,32'h100, 0,0,1,1));
        vecs.push_back(mkv(1,0, 0,5'h00,32'h0,0,32'h0, 0,5'h00,32'h0, 0,0,5'h13,32'hDEADBEEF,1,32'h100, 0,0,1,1));
        // Flush back to the reset state, then a simultaneous push: the ALU wins the first tie
        vecs.push_back(mkv(1,1, 0,5'h00,32'h0,0,32'h0, 0,5'h00,32'h0, 0,0,5'h00,32'h0,0,32'h0, 0,0,1,1));
        vecs.push_back(mkv(1,0, 1,5'h01,32'h1,0,32'h44, 1,5'h02,32'h2, 0,0,5'h00,32'h0,0,32'h0, 1,1,1,1));
        vecs.push_back(mkv(1,0, 0,5'h00,32'h0,0,32'h0, 0,5'h00,32'h0, 1,0,5'h01,32'h1,0,32'h44, 0,1,1,1));
        vecs.push_back(mkv(1,0, 0,5'h00,32'h0,0,32'h0, 0,5'h00,32'h0, 1,1,5'h02,32'h2,0,32'h0, 0,0,1,1));
        vecs.push_back(mkv(1,0, 0,5'h00,32'h0,0,32'h0, 0,5'h00,32'h0, 0,1,5'h02,32'h2,0,32'h0, 0,0,1,1));
        // Flush, then continuous dual load, gated by ready
        vecs.push_back(mkv(1,1, 0,5'h00,32'h0,0,32'h0, 0,5'h00,32'h0, 0,0,5'h00,32'h0,0,32'h0, 0,0,1,1));
        vecs.push_back(mkv(1,0, 1,5'h0A,32'h10,1,32'h200, 1,5'h18,32'h20, 0,0,5'h00,32'h0,0,32'h0, 1,1,1,1));
        vecs.push_back(mkv(1,0, 1,5'h0B,32'h11,1,32'h204, 1,5'h19,32'h21, 1,0,5'h0A,32'h10,1,32'h200, 1,2,1,0));
        vecs.push_back(mkv(1,0, 1,5'h0C,32'h12,1,32'h208, 0,5'h00,32'h0, 1,1,5'h18,32'h20,0,32'h0, 2,1,0,1));
        vecs.push_back(mkv(1,0, 0,5'h00,32'h0,0,32'h0, 1,5'h1A,32'h22, 1,0,5'h0B,32'h11,1,32'h204, 1,2,1,0));
        vecs.push_back(mkv(1,0, 1,5'h0D,32'h13,1,32'h20C, 0,5'h00,32'h0, 1,1,5'h19,32'h21,0,32'h0, 2,1,0,1));
        vecs.push_back(mkv(1,0, 0,5'h00,32'h0,0,32'h0, 0,5'h00,32'h0, 1,0,5'h0C,32'h12,1,32'h208, 1,1,1,1));
        vecs.push_back(mkv(1,0, 0,5'h00,32'h0,0,32'h0, 0,5'h00,32'h0, 1,1,5'h1A,32'h22,0,32'h0, 1,0,1,1));
        vecs.push_back(mkv(1,0, 0,5'h00,32'h0,0,32'h0, 0,5'h00,32'h0, 1,0,5'h0D,32'h13,1,32'h20C, 0,0,1,1));
        vecs.push_back(mkv(1,0, 0,5'h00,32'h0,0,32'h0, 0,5'h00,32'h0, 0,0,5'h0D,32'h13,1,32'h20C, 0,0,1,1));
        // Fill the ALU FIFO, then flush with an LSB push offered: nothing flushed is ever broadcast
        vecs.push_back(mkv(1,1, 0,5'h00,32'h0,0,32'h0, 0,5'h00,32'h0, 0,0,5'h00,32'h0,0,32'h0, 0,0,1,1));
        vecs.push_back(mkv(1,0, 1,5'h03,32'hAA,0,32'h300, 1,5'h11,32'h55, 0,0,5'h00,32'h0,0,32'h0, 1,1,1,1));
        vecs.push_back(mkv(1,0, 1,5'h04,32'hBB,1,32'h304, 1,5'h12,32'h66, 1,0,5'h03,32'hAA,0,32'h300, 1,2,1,0));
        vecs.push_back(mkv(1,0, 1,5'h05,32'hCC,0,32'h308, 0,5'h00,32'h0, 1,1,5'h11,32'h55,0,32'h0, 2,1,0,1));
        vecs.push_back(mkv(1,1, 0,5'h00,32'h0,0,32'h0, 1,5'h13,32'h77, 0,0,5'h00,32'h0,0,32'h0, 0,0,1,1));
        vecs.push_back(mkv(1,0, 0,5'h00,32'h0,0,32'h0, 0,5'h00,32'h0, 0,0,5'h00,32'h0,0,32'h0, 0,0,1,1));
        vecs.push_back(mkv(1,0, 0,5'h00,32'h0,0,32'h0, 0,5'h00,32'h0, 0,0,5'h00,32'h0,0,32'h0, 0,0,1,1));

        idle = vecs[0];
        drive(idle);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_vec(i, vecs[i]);
        end

        // Stall: one LSB entry is buffered, then rdy is held low for 3 cycles with pushes offered
        drive(idle);
        bus.lsb_valid   = 1'b1;
        bus.lsb_rob_pos = 5'h1F;
        bus.lsb_val     = 32'h99;
        @(posedge clk);
        #1;
        chk("stall_setup_lc", 64'(bus.lsb_count), 64'd1);
        chk("stall_setup_v", 64'(bus.cdb_valid), 64'd0);

        bus.rdy         = 1'b0;
        bus.alu_valid   = 1'b1;
        bus.alu_rob_pos = 5'h07;
        bus.alu_val     = 32'hEE;
        bus.lsb_rob_pos = 5'h08;
        bus.lsb_val     = 32'hEF;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("stall_lc", 64'(bus.lsb_count), 64'd1);
            chk("stall_ac", 64'(bus.alu_count), 64'd0);
            chk("stall_v", 64'(bus.cdb_valid), 64'd0);
        end

        // After rdy returns, the single buffered entry is broadcast exactly once
        drive(idle);
        hits  = 0;
        first = -1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (bus.cdb_valid) begin
                hits++;
                if (first < 0) first = c;
                chk("resume_val", 64'(bus.cdb_val), 64'h99);
                chk("resume_pos", 64'(bus.cdb_rob_pos), 64'h1F);
                chk("resume_src", 64'(bus.cdb_src), 64'd1);
            end
        end
        chk("resume_once", 64'(hits), 64'd1);
        chk("resume_first_cycle", 64'(first), 64'd0);
        chk("resume_lc", 64'(bus.lsb_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
